// File: rtl/clk_div_pkg.sv
// Shared definitions for the clk_div_bank programmable clock-enable divider.
//   CwDefault  : default counter/config width
//   CwMax      : widest config the legality helper can judge
//   div_cfg_t  : one channel configuration (period, high phase, enable)
//   cfg_legal(): judges whether a configuration write may be accepted
package clk_div_pkg;

  localparam int unsigned CwDefault = 16;
  localparam int unsigned CwMax     = 32;

  // Fields are CwMax wide so one typedef serves every CW <= CwMax; callers zero-extend.
  typedef struct packed {
    logic [CwMax-1:0] div;
    logic [CwMax-1:0] high;
    logic             en;
  } div_cfg_t;

  // A disable is always legal; an enable needs div >= 2 and 1 <= high <= div-1.
  function automatic logic cfg_legal(div_cfg_t cfg);
    return !cfg.en || ((cfg.div >= CwMax'(2)) && (cfg.high >= CwMax'(1)) &&
                       (cfg.high < cfg.div));
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: shadow config, active config, period counter and apply logic.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   wr_i          : load shadow from div_i/high_i/en_i and mark it pending
//   div_out_o     : registered divided waveform
//   tick_o        : registered pulse in the first cycle of each period
//   pending_o     : shadow config is waiting for the next period boundary
module clk_div_chan #(
  parameter int unsigned CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_i,
  input  logic [CW-1:0] div_i,
  input  logic [CW-1:0] high_i,
  input  logic          en_i,
  output logic          div_out_o,
  output logic          tick_o,
  output logic          pending_o
);

  logic [CW-1:0] div_a_q, div_a_d, high_a_q, high_a_d, cnt_q, cnt_d;
  logic [CW-1:0] div_s_q, div_s_d, high_s_q, high_s_d;
  logic          en_a_q, en_a_d, en_s_q, en_s_d;
  logic          pending_q, pending_d, div_out_q, div_out_d, tick_q, tick_d;
  logic          last, apply;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    div_a_d   = div_a_q;
    high_a_d  = high_a_q;
    en_a_d    = en_a_q;
    cnt_d     = cnt_q;
    div_s_d   = div_s_q;
    high_s_d  = high_s_q;
    en_s_d    = en_s_q;
    pending_d = pending_q;
    div_out_d = div_out_q;
    tick_d    = tick_q;

    // div_a >= 2 whenever enabled, so div_a-1 never wraps while it matters.
    last    = (cnt_q == div_a_q - CW'(1));
    apply   = pending_q & (~en_a_q | last);
    cnt_nxt = last ? '0 : cnt_q + CW'(1);

    if (apply) begin
      div_a_d   = div_s_q;
      high_a_d  = high_s_q;
      en_a_d    = en_s_q;
      cnt_d     = '0;
      pending_d = 1'b0;
      // high >= 1 is guaranteed for an enabled config, so the first cycle is high.
      div_out_d = en_s_q;
      tick_d    = en_s_q;
    end else if (en_a_q) begin
      cnt_d     = cnt_nxt;
      div_out_d = (cnt_nxt < high_a_q);
      tick_d    = (cnt_nxt == '0);
    end else begin
      cnt_d     = '0;
      div_out_d = 1'b0;
      tick_d    = 1'b0;
    end

    // The top blocks writes while pending, so this never meets an apply; if it did,
    // the fresh shadow stays pending and is applied at the following boundary.
    if (wr_i) begin
      div_s_d   = div_i;
      high_s_d  = high_i;
      en_s_d    = en_i;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_a_q   <= CW'(2);
      high_a_q  <= CW'(1);
      en_a_q    <= 1'b0;
      cnt_q     <= '0;
      div_s_q   <= CW'(2);
      high_s_q  <= CW'(1);
      en_s_q    <= 1'b0;
      pending_q <= 1'b0;
      div_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      div_a_q   <= div_a_d;
      high_a_q  <= high_a_d;
      en_a_q    <= en_a_d;
      cnt_q     <= cnt_d;
      div_s_q   <= div_s_d;
      high_s_q  <= high_s_d;
      en_s_q    <= en_s_d;
      pending_q <= pending_d;
      div_out_q <= div_out_d;
      tick_q    <= tick_d;
    end
  end

  assign div_out_o = div_out_q;
  assign tick_o    = tick_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock-enable divider with glitch-free runtime reconfiguration.
//   sysclk, rst_n      : clock, asynchronous active-low reset
//   cfg_valid/ready    : config write handshake; ready is low while the target is pending
//   cfg_ch             : target channel (>= NCH is rejected)
//   cfg_div/high/en    : period, high-phase length, enable
//   cfg_err            : one-cycle pulse after a rejected write
//   div_out, tick      : per-channel waveform and period-start pulse
//   pending            : per-channel staged config not yet applied
// CW must not exceed clk_div_pkg::CwMax.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = CwDefault,
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           sysclk,
  input  logic           rst_n,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_div,
  input  logic [CW-1:0]  cfg_high,
  input  logic           cfg_en,
  output logic           cfg_err,
  output logic [NCH-1:0] div_out,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] pending
);

  localparam int unsigned NPad = 2 ** CHW;

  // Padding reads as "not pending", so out-of-range channels look ready and get rejected.
  logic [NPad-1:0] pend_pad;
  div_cfg_t        req;
  logic            in_range, accept, legal;
  logic [NCH-1:0]  wr;
  logic            err_q, err_d;

  always_comb begin
    req            = '0;
    req.div[CW-1:0]  = cfg_div;
    req.high[CW-1:0] = cfg_high;
    req.en           = cfg_en;

    pend_pad  = NPad'(pending);
    cfg_ready = ~pend_pad[cfg_ch];
    in_range  = (32'(cfg_ch) < NCH);
    accept    = cfg_valid & cfg_ready;
    legal     = in_range & cfg_legal(req);
    err_d     = accept & ~legal;

    for (int unsigned i = 0; i < NCH; i++) begin
      wr[i] = accept & legal & (32'(cfg_ch) == i);
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign cfg_err = err_q;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clk_div_chan #(
      .CW (CW)
    ) u_chan (
      .clk_i     (sysclk),
      .rst_ni    (rst_n),
      .wr_i      (wr[g]),
      .div_i     (cfg_div),
      .high_i    (cfg_high),
      .en_i      (cfg_en),
      .div_out_o (div_out[g]),
      .tick_o    (tick[g]),
      .pending_o (pending[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank (NCH=3 so cfg_ch=3 is an out-of-range channel).
// The stimulus process pushes, once per cycle, the hand-derived expected outputs for that
// cycle; the monitor pops and compares on every falling edge.
module tb_clk_div_bank;

  localparam int unsigned NCH = 3;
  localparam int unsigned CW  = 16;

  logic           sysclk = 1'b0;
  logic           rst_n  = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [1:0]     cfg_ch = 2'd0;
  logic [CW-1:0]  cfg_div = '0;
  logic [CW-1:0]  cfg_high = '0;
  logic           cfg_en = 1'b0;
  logic           cfg_err;
  logic [NCH-1:0] div_out, tick, pending;

  clk_div_bank #(
    .NCH (NCH),
    .CW  (CW)
  ) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_en    (cfg_en),
    .cfg_err   (cfg_err),
    .div_out   (div_out),
    .tick      (tick),
    .pending   (pending)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [NCH-1:0] d;
    logic [NCH-1:0] t;
    logic [NCH-1:0] p;
    logic           r;
    logic           e;
    int             n;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Expected-waveform descriptors per channel, updated by the stimulus at hand-computed cycles.
  int cyc_n = 0;
  bit run [NCH];
  int dv  [NCH];
  int hg  [NCH];
  int t0  [NCH];
  bit pend_m [NCH];
  bit err_now = 1'b0, err_next = 1'b0;

  always @(negedge sysclk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      checks++;
      if (div_out !== x.d || tick !== x.t || pending !== x.p || cfg_ready !== x.r ||
          cfg_err !== x.e) begin
        errors++;
        $display("FAIL cyc%0d outputs: got div=%b tick=%b pend=%b rdy=%b err=%b, want div=%b tick=%b pend=%b rdy=%b err=%b",
                 x.n, div_out, tick, pending, cfg_ready, cfg_err, x.d, x.t, x.p, x.r, x.e);
      end
    end
  end

  task automatic next_cycle();
    @(posedge sysclk);
    #1;
    cyc_n++;
    err_now   = err_next;
    err_next  = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic push_exp();
    exp_t x;
    int   ph;
    int   ci;
    for (int ch = 0; ch < NCH; ch++) begin
      if (run[ch]) begin
        ph = (cyc_n - t0[ch]) % dv[ch];
        x.d[ch] = (ph < hg[ch]);
        x.t[ch] = (ph == 0);
      end else begin
        x.d[ch] = 1'b0;
        x.t[ch] = 1'b0;
      end
      x.p[ch] = pend_m[ch];
    end
    ci  = int'(cfg_ch);
    x.r = (ci < NCH) ? !pend_m[ci] : 1'b1;
    x.e = err_now;
    x.n = cyc_n;
    q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      push_exp();
    end
  endtask

  task automatic write(input int ch, input int div, input int high, input bit en);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_div   = CW'(div);
    cfg_high  = CW'(high);
    cfg_en    = en;
  endtask

  // Enable write to a disabled channel: pending next cycle, first period the cycle after.
  task automatic start_chan(input int ch, input int div, input int high);
    next_cycle();
    write(ch, div, high, 1'b1);
    push_exp();
    next_cycle();
    pend_m[ch] = 1'b1;
    push_exp();
    next_cycle();
    pend_m[ch] = 1'b0;
    run[ch] = 1'b1;
    dv[ch]  = div;
    hg[ch]  = high;
    t0[ch]  = cyc_n;
    push_exp();
  endtask

  task automatic bad_write(input int ch, input int div, input int high);
    next_cycle();
    write(ch, div, high, 1'b1);
    err_next = 1'b1;
    push_exp();
    next_cycle();
    push_exp();
  endtask

  initial begin
    for (int ch = 0; ch < NCH; ch++) begin
      run[ch] = 1'b0; dv[ch] = 2; hg[ch] = 1; t0[ch] = 0; pend_m[ch] = 1'b0;
    end

    // Reset held for 3 cycles, then released between edges.
    idle(3);
    next_cycle();
    rst_n = 1'b1;
    push_exp();
    idle(2);

    // ch0 div=4 high=2: 1,1,0,0 with tick on the first 1.
    start_chan(0, 4, 2);
    idle(8);

    // ch1 div=5 high=2 alongside ch0.
    start_chan(1, 5, 2);
    idle(10);

    // ch2 div=6 high=3, then reprogram to div=3 high=1 while cnt=2.
    start_chan(2, 6, 3);
    idle(1);
    next_cycle();
    write(2, 3, 1, 1'b1);
    push_exp();
    next_cycle();
    pend_m[2] = 1'b1;
    push_exp();
    idle(2);
    next_cycle();
    pend_m[2] = 1'b0;
    dv[2] = 3; hg[2] = 1; t0[2] = cyc_n;
    push_exp();
    idle(6);

    // Rejected writes: pulse on cfg_err, nothing staged.
    bad_write(1, 1, 0);
    bad_write(1, 4, 4);
    bad_write(1, 4, 0);
    bad_write(3, 4, 2);
    idle(2);

    // Disable ch0 while cnt=1: finishes the period, then holds 0.
    cfg_ch = 2'd0;
    while ((cyc_n + 1 - t0[0]) % 4 != 1) begin
      next_cycle();
      push_exp();
    end
    next_cycle();
    write(0, 0, 0, 1'b0);
    push_exp();
    next_cycle();
    pend_m[0] = 1'b1;
    push_exp();
    idle(1);
    next_cycle();
    pend_m[0] = 1'b0;
    run[0] = 1'b0;
    push_exp();
    idle(4);

    // Async reset mid-period: outputs fall before the next clock edge.
    next_cycle();
    #2;
    rst_n = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      run[ch] = 1'b0; pend_m[ch] = 1'b0;
    end
    err_now = 1'b0;
    push_exp();
    idle(2);
    next_cycle();
    rst_n = 1'b1;
    push_exp();
    idle(4);

    // Recovery after reset needs a fresh enable.
    start_chan(0, 3, 1);
    idle(6);

    @(negedge sysclk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
